// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instruction_loader_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int WORD_W             = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 5;
  localparam int BYTE_IDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// Big-endian byte-to-word shifter; Word is valid in the cycle WordComplete is high.
module byte_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              ByteStrobe,
  input  logic [7:0]        ByteData,
  output logic [WORD_W-1:0] Word,
  output logic              WordComplete
);

  // Only the three earlier bytes need storage; the fourth is taken straight from the input.
  logic [WORD_W-9:0]     shift_q;
  logic [BYTE_IDX_W-1:0] idx_q;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (ByteStrobe) begin
      shift_q <= {shift_q[WORD_W-17:0], ByteData};
      idx_q   <= idx_q + BYTE_IDX_W'(1);
    end
  end

  assign Word         = {shift_q, ByteData};
  assign WordComplete = ByteStrobe && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a count-prefixed byte stream into instruction memory, holding the CPU meanwhile.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        MemWriteEnable,
  output logic [31:0] MemWriteAddress,
  output logic [31:0] MemWriteData,
  output logic        CpuHold,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  // One extra index bit so a full load never wraps before reaching DONE.
  localparam int          IDX_W     = DEPTH_LOG2 + 1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << DEPTH_LOG2;

  state_t            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;

  logic              byte_ready_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              wr_en_q;
  logic [31:0]       wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              transfer;
  logic              asm_clear;
  logic              asm_strobe;
  logic [WORD_W-1:0] asm_word;
  logic              word_complete;

  assign transfer   = ByteValid && byte_ready_q;
  assign asm_strobe = transfer && (state_q == ST_DATA);

  byte_word_assembler u_asm (
    .Clock        (Clock),
    .Reset        (Reset),
    .Clear        (asm_clear),
    .ByteStrobe   (asm_strobe),
    .ByteData     (ByteData),
    .Word         (asm_word),
    .WordComplete (word_complete)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    asm_clear  = 1'b0;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_COUNT;
      ST_COUNT: begin
        if (transfer) begin
          if (ByteData == 8'd0) begin
            state_d = ST_DONE;
          end else if (32'(ByteData) > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            count_d    = ByteData;
            word_idx_d = '0;
            asm_clear  = 1'b1;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: if (word_complete) state_d = ST_WRITE;
      ST_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (32'(word_idx_q) + 32'd1 == 32'(count_q)) state_d = ST_DONE;
        else                                         state_d = ST_DATA;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: if (Start) state_d = ST_COUNT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_ready_q <= (state_d == ST_COUNT) || (state_d == ST_DATA);
      cpu_hold_q   <= (state_d != ST_IDLE);
      busy_q       <= (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_WRITE);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERROR);
      wr_en_q      <= (state_d == ST_WRITE);
      wr_addr_q    <= (state_d == ST_WRITE) ? (32'(word_idx_d) << 2) : 32'd0;
      wr_data_q    <= (state_d == ST_WRITE) ? asm_word : 32'd0;
    end
  end

  assign ByteReady       = byte_ready_q;
  assign CpuHold         = cpu_hold_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign Error           = error_q;
  assign MemWriteEnable  = wr_en_q;
  assign MemWriteAddress = wr_addr_q;
  assign MemWriteData    = wr_data_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: hand-computed writes, handshakes and status flags.
module tb_instruction_loader;

  logic        Clock = 1'b0;
  logic        Reset, Start, ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady, MemWriteEnable, CpuHold, Busy, Done, Error;
  logic [31:0] MemWriteAddress, MemWriteData;

  int vectors = 0;
  int miscompares = 0;
  int rp = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instruction_loader dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Start           (Start),
    .ByteValid       (ByteValid),
    .ByteData        (ByteData),
    .ByteReady       (ByteReady),
    .MemWriteEnable  (MemWriteEnable),
    .MemWriteAddress (MemWriteAddress),
    .MemWriteData    (MemWriteData),
    .CpuHold         (CpuHold),
    .Busy            (Busy),
    .Done            (Done),
    .Error           (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (MemWriteEnable === 1'b1) begin
      wr_addr_q.push_back(MemWriteAddress);
      wr_data_q.push_back(MemWriteData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents one byte and holds it until it is accepted at a clock edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    ByteValid = 1'b1;
    ByteData  = b;
    n = 0;
    while (ByteReady !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("send_timeout", 32'(n < 20), 32'd1);
    step();
    ByteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    if (rp < wr_addr_q.size()) begin
      chk({tag, "_addr"}, wr_addr_q[rp], addr);
      chk({tag, "_data"}, wr_data_q[rp], data);
    end else begin
      chk({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(rp + 1));
    end
    rp++;
  endtask

  task automatic start_load();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    logic [31:0] w;

    // 1: reset with busy-looking inputs
    Reset = 1'b1; Start = 1'b1; ByteValid = 1'b1; ByteData = 8'hAA;
    step(); step();
    chk("t1_flags", {26'd0, ByteReady, MemWriteEnable, CpuHold, Busy, Done, Error}, 32'd0);
    chk("t1_addr", MemWriteAddress, 32'd0);
    chk("t1_data", MemWriteData, 32'd0);
    Reset = 1'b0; Start = 1'b0; ByteValid = 1'b0;
    step();
    chk("t1_idle", {30'd0, ByteReady, CpuHold}, 32'd0);

    // 2: two-word load, continuous valid
    start_load();
    chk("t2_count_flags", {29'd0, ByteReady, CpuHold, Busy}, 32'h7);
    send_byte(8'h02);
    send_word(32'h00432020);
    chk("t2_wr0_en", {31'd0, MemWriteEnable}, 32'd1);
    chk("t2_wr0_rdy", {31'd0, ByteReady}, 32'd0);
    chk("t2_wr0_addr", MemWriteAddress, 32'h0);
    chk("t2_wr0_data", MemWriteData, 32'h00432020);
    send_word(32'h8C440004);
    chk("t2_wr1_addr", MemWriteAddress, 32'h4);
    chk("t2_wr1_data", MemWriteData, 32'h8C440004);
    step();
    chk("t2_done_flags", {28'd0, Done, CpuHold, Busy, MemWriteEnable}, 32'hC);
    chk("t2_done_addr", MemWriteAddress, 32'd0);
    step();
    chk("t2_idle_flags", {29'd0, Done, CpuHold, ByteReady}, 32'd0);
    expect_write("t2_q0", 32'h0, 32'h00432020);
    expect_write("t2_q1", 32'h4, 32'h8C440004);

    // 3: zero count
    start_load();
    send_byte(8'h00);
    chk("t3_done", {30'd0, Done, MemWriteEnable}, 32'h2);
    step();
    chk("t3_idle", {29'd0, Done, CpuHold, Busy}, 32'd0);
    chk("t3_nowrite", 32'(wr_addr_q.size()), 32'd2);

    // 4: out-of-range count, then recovery
    start_load();
    send_byte(8'h21);
    ByteValid = 1'b1; ByteData = 8'h55;
    for (int i = 0; i < 10; i++) begin
      chk("t4_err_flags", {29'd0, Error, CpuHold, ByteReady}, 32'h6);
      step();
    end
    ByteValid = 1'b0;
    start_load();
    chk("t4_err_clear", {30'd0, Error, ByteReady}, 32'h1);
    send_byte(8'h01);
    send_word(32'h08100000);
    chk("t4_wr_addr", MemWriteAddress, 32'h0);
    chk("t4_wr_data", MemWriteData, 32'h08100000);
    step();
    chk("t4_done", {30'd0, Done, Error}, 32'h2);
    expect_write("t4_q", 32'h0, 32'h08100000);
    step();

    // 5: backpressure with gaps between bytes
    start_load();
    send_byte(8'h01);
    w = 32'hDEADBEEF;
    for (int i = 3; i >= 0; i--) begin
      step();
      send_byte(w[i*8 +: 8]);
    end
    step();
    chk("t5_done_a", {31'd0, Done}, 32'd1);
    expect_write("t5_q0", 32'h0, 32'hDEADBEEF);
    step();
    start_load();
    send_byte(8'h02);
    w = 32'h11223344;
    for (int i = 3; i >= 0; i--) begin
      step();
      send_byte(w[i*8 +: 8]);
    end
    // first byte of the next word is offered during WRITE with no gap
    send_byte(8'h55);
    w = 32'h00667788;
    for (int i = 2; i >= 0; i--) begin
      step();
      send_byte(w[i*8 +: 8]);
    end
    step();
    chk("t5_done_b", {31'd0, Done}, 32'd1);
    expect_write("t5_q1", 32'h0, 32'h11223344);
    expect_write("t5_q2", 32'h4, 32'h55667788);
    step();

    // 6: full 32-word load, then reset in the middle of a reload
    start_load();
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
      send_word(w);
      if (i == 31) begin
        chk("t6_last_addr", MemWriteAddress, 32'h7C);
        chk("t6_last_data", MemWriteData, 32'h1F202122);
      end
    end
    step();
    chk("t6_done", {31'd0, Done}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      expect_write("t6_q", 32'(i) << 2, {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
    end
    step();
    start_load();
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    Reset = 1'b1;
    step();
    chk("t6_rst_flags", {26'd0, ByteReady, MemWriteEnable, CpuHold, Busy, Done, Error}, 32'd0);
    Reset = 1'b0;
    repeat (3) step();
    chk("t6_idle_flags", {26'd0, ByteReady, MemWriteEnable, CpuHold, Busy, Done, Error}, 32'd0);
    chk("t6_idle_addr", MemWriteAddress, 32'd0);
    chk("t6_write_total", 32'(wr_addr_q.size()), 32'd38);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Sequential writer for the instruction memory.
- Receives a byte stream with valid/ready handshake: one count byte N, then 4·N bytes.
- Assembles big-endian 32-bit instruction words and issues one word-aligned write per word to the writable instruction memory port.
- Holds the CPU (CpuHold) from Start until the load completes or fails; used to boot programs without resynthesis.

Parameters:
DEPTH_LOG2, 5, log2 of instruction memory depth in words (32 words; memory indexed by Address[DEPTH_LOG2+1:2])

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin a load; honoured only in IDLE or ERROR
ByteValid  input  1  ByteData valid this cycle
ByteData  input  8  stream byte
ByteReady  output  1  loader accepts a byte this cycle; transfer = ByteValid & ByteReady
MemWriteEnable  output  1  write strobe to instruction memory, one cycle per word
MemWriteAddress  output  32  byte address, word-aligned (word index << 2, bits [1:0] = 0)
MemWriteData  output  32  assembled instruction word
CpuHold  output  1  CPU must stall and PC held while high
Busy  output  1  high in COUNT, DATA, WRITE
Done  output  1  one-cycle pulse at successful completion
Error  output  1  sticky; count byte out of range

Behaviour:
- Interface: one clock (Clock); reset (Reset) is synchronous and active-high.
- Reset values: state IDLE; every output 0; word index, byte index and assembly register 0.
- States: IDLE, COUNT, DATA, WRITE, DONE, ERROR.
- IDLE:
  - ByteReady=0, CpuHold=0.
  - Start -> COUNT next cycle.
- COUNT:
  - ByteReady=1, CpuHold=1, Busy=1.
  - On transfer with byte value N:
    - N=0 -> DONE.
    - N > 2^DEPTH_LOG2 -> ERROR.
    - Otherwise latch N, clear word and byte index -> DATA.
- DATA:
  - ByteReady=1.
  - Each transfer: assembly <= {assembly[23:0], ByteData}; byte index +1 (2-bit).
  - Transfer with byte index=3 -> WRITE.
  - No transfer: state and registers hold.
- WRITE:
  - Exactly one cycle; ByteReady=0.
  - MemWriteEnable=1, MemWriteAddress = word index << 2, MemWriteData = assembly.
  - Then word index +1.
  - If word index+1 == N -> DONE, else DATA.
  - ByteValid during WRITE is not consumed; the source holds the byte.
- DONE:
  - One cycle: Done=1, CpuHold=1, Busy=0.
  - -> IDLE; CpuHold drops the following cycle.
- ERROR:
  - Error=1, CpuHold=1, ByteReady=0.
  - Start -> COUNT and clears Error the same cycle.
  - Only Reset or Start exits ERROR.
- Start outside IDLE/ERROR: ignored.
- Latency and throughput:
  - Write strobe appears the cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
- Write outputs:
  - MemWriteAddress and MemWriteData are registered and stable during the WRITE cycle.
  - Outside WRITE both are 0.
- Reset mid-load: return to IDLE immediately; discard any partial word; words already written stay in memory.
- N = 2^DEPTH_LOG2 (full load): the last address is (2^DEPTH_LOG2 − 1) << 2 = 0x7C at default. Word index must not wrap before DONE.

Decomposition:
- Shared package: state encoding constants, BYTES_PER_WORD = 4, word width 32, default DEPTH_LOG2.
- One sub-module, byte_word_assembler:
  - Shift register plus 2-bit byte counter.
  - Ports: Clock, Reset, Clear, ByteStrobe, ByteData, Word, WordComplete.
- FSM, indices and write port live in instruction_loader.

Test Plan:
1. Reset held 2 cycles with ByteValid=1, Start=1 -> all outputs 0, ByteReady=0, no write.
2. Start; stream 02, 00 43 20 20, 8C 44 00 04 with ByteValid=1 continuously ->
   - write addr 0x0 data 0x00432020, then addr 0x4 data 0x8C440004;
   - Done pulses 1 cycle after second write;
   - CpuHold=1 from cycle after Start through DONE, 0 afterwards.
3. Start; count byte 00 -> no MemWriteEnable, Done pulse the cycle after count transfer, then IDLE.
4. Start; count byte 0x21 (33) -> Error=1, CpuHold=1, ByteReady=0 held for 10 cycles; then Start, stream 01 08 10 00 00 -> Error clears, write addr 0x0 data 0x08100000, Done.
5. Backpressure: N=1, ByteValid toggling every other cycle, and a byte presented during WRITE of a 2-word load ->
   - no byte lost or duplicated;
   - words written are exactly the sent big-endian values.
6. N=32 full load of incrementing words, Reset asserted after 2 bytes of a subsequent reload ->
   - first load's last write at 0x7C;
   - reload produces no write and returns to IDLE with all outputs 0.
